// File: rtl/interface_gpio.sv
`default_nettype none
// ============================================================================
//  Module      : interface_gpio
//  Description : Parametrised GPIO peripheral on the IO bus. It drives LEDs,
//                synchronises and debounces switches, latches sticky change
//                flags (write-1-to-clear), and raises a maskable interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module interface_gpio #(
   parameter int   DEVICE_NUM_LED     = 8,
   parameter int   DEVICE_NUM_SWITCH  = 8,
   parameter int   LED_NUM            = DEVICE_NUM_LED,
   parameter int   SWITCH_NUM         = DEVICE_NUM_SWITCH,
   parameter int   DEBOUNCE_CYCLES    = 16,
   parameter int   IO_BUS_WIDTH_ADDR  = 32,
   parameter int   IO_BUS_WIDTH_DATA  = 32,
   parameter int   IO_BUS_WIDTH_CTRL  = 4,
   parameter int   IO_BUS_CTRL_WE     = 0,
   parameter int   IO_CALL_LOWERADDR  = 2,
   parameter int   IO_CALL_HIGHERADDR = 4,
   parameter logic IO_CTRL_WRITE      = 1'b1,
   parameter logic IO_CTRL_READ       = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         BG,
   input  logic [IO_BUS_WIDTH_ADDR-1:0] addr,
   input  logic [IO_BUS_WIDTH_CTRL-1:0] ctrl,
   inout  wire  [IO_BUS_WIDTH_DATA-1:0] data,
   input  logic [SWITCH_NUM-1:0]        switch,
   output logic [LED_NUM-1:0]           led,
   output logic                         irq
);

   localparam int SEL_W = IO_CALL_HIGHERADDR - IO_CALL_LOWERADDR + 1;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [SEL_W-1:0] SEL_CTRL   = SEL_W'(0);
   localparam logic [SEL_W-1:0] SEL_LED    = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_SWITCH = SEL_W'(2);
   localparam logic [SEL_W-1:0] SEL_STATUS = SEL_W'(3);
   localparam logic [SEL_W-1:0] SEL_MASK   = SEL_W'(4);

   // Counter value on which the next disagreeing cycle completes the debounce
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SEL_W-1:0]             sel;
   logic                         bus_wr;
   logic                         bus_rd;
   logic [1:0]                   ctrl_q;     // bit0 LED_EN, bit1 IRQ_EN
   logic [LED_NUM-1:0]           led_q;
   logic [SWITCH_NUM-1:0]        mask_q;
   logic [SWITCH_NUM-1:0]        status_q;
   logic [SWITCH_NUM-1:0]        stable;
   logic [SWITCH_NUM-1:0]        chg;
   logic [SWITCH_NUM-1:0]        w1c;
   logic [IO_BUS_WIDTH_DATA-1:0] rdata_sel;
   logic [IO_BUS_WIDTH_DATA-1:0] rdata_q;
   logic                         unused_bits;

   assign sel    = addr[IO_CALL_HIGHERADDR:IO_CALL_LOWERADDR];
   assign bus_wr = BG && (ctrl[IO_BUS_CTRL_WE] == IO_CTRL_WRITE);
   assign bus_rd = BG && (ctrl[IO_BUS_CTRL_WE] == IO_CTRL_READ);

   // Bus is only driven during a granted read
   assign data = bus_rd ? rdata_q : {IO_BUS_WIDTH_DATA{1'bz}};

   assign led = ctrl_q[0] ? led_q : '0;

   // Write-1-to-clear strobe for the change flags
   assign w1c = (bus_wr && (sel == SEL_STATUS)) ? data[SWITCH_NUM-1:0] : '0;

   // Bus bits outside the used fields are intentionally ignored
   assign unused_bits = ^{addr, ctrl, data};

   // Per-channel synchroniser and debouncer
   for (genvar i = 0; i < SWITCH_NUM; i++) begin : g_ch
      logic [1:0]       sync_q;
      logic [CNT_W-1:0] cnt_q;
      logic             stable_q;

      // Stable level flips after enough consecutive disagreeing cycles
      assign chg[i]    = (sync_q[1] != stable_q) && (cnt_q == CNT_LAST);
      assign stable[i] = stable_q;

      // Two-flop synchroniser followed by the agreement counter
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q   <= 2'b00;
            cnt_q    <= '0;
            stable_q <= 1'b0;
         end else begin
            sync_q <= {sync_q[0], switch[i]};
            if (sync_q[1] == stable_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_q    <= '0;
               stable_q <= sync_q[1];
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   // Read-data select, zero-extended to the bus width
   always_comb begin
      rdata_sel = '0;
      case (sel)
         SEL_CTRL:   rdata_sel[1:0]            = ctrl_q;
         SEL_LED:    rdata_sel[LED_NUM-1:0]    = led_q;
         SEL_SWITCH: rdata_sel[SWITCH_NUM-1:0] = stable;
         SEL_STATUS: rdata_sel[SWITCH_NUM-1:0] = status_q;
         SEL_MASK:   rdata_sel[SWITCH_NUM-1:0] = mask_q;
         default:    rdata_sel                 = '0;
      endcase
   end

   // Read/write configuration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= 2'b01;
         led_q  <= '0;
         mask_q <= '0;
      end else if (bus_wr) begin
         case (sel)
            SEL_CTRL: ctrl_q <= data[1:0];
            SEL_LED:  led_q  <= data[LED_NUM-1:0];
            SEL_MASK: mask_q <= data[SWITCH_NUM-1:0];
            default:  ;
         endcase
      end
   end

   // Sticky change flags; a new change wins over a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= '0;
      end else begin
         status_q <= (status_q & ~w1c) | chg;
      end
   end

   // Registered interrupt request and read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq     <= 1'b0;
         rdata_q <= '0;
      end else begin
         irq     <= ctrl_q[1] & (|(status_q & mask_q));
         rdata_q <= rdata_sel;
      end
   end

endmodule
`default_nettype wire
